gf_delay_line: RTL

- Parametrised, stallable delay line for operand and partial-product skewing between systolic array cells of the GF(2^m) multiplier.
- Generalises the fixed 7-bit single-stage delay register to any width and depth.
- Adds per-stage valid tracking, a global advance enable for array stall, and a synchronous flush.
- Provides an occupancy count and optional zero-squashing of bubbles, so invalid slots inject the GF additive identity (0) into downstream XOR accumulators.

---
 rtl/gf_pkg.sv | 17 +
 rtl/gf_delay_stage.sv | 56 +++++
 rtl/gf_delay_line.sv | 83 ++++++++
 3 files changed

// File: rtl/gf_pkg.sv
// gf_pkg: shared definitions for the GF(2^m) multiplier array.
//   GF_M  : default field width, used as the data width at array instantiation sites.
//   clog2 : ceiling log2 for elaboration-time sizing of counters.
package gf_pkg;

  localparam int GF_M = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_delay_stage.sv
// gf_delay_stage: one register slot of the skewing delay line.
// Ports:
//   clk    in  rising-edge clock
//   rst    in  asynchronous active-low reset (clears data and valid)
//   en     in  1 = load from the previous slot, 0 = hold
//   clr    in  synchronous flush; beats en
//   squash in  1 = load all-zero data when v_in is 0
//   v_in   in  valid of the previous slot (or line input)
//   d_in   in  data of the previous slot (or line input)
//   v_out  out registered valid
//   d_out  out registered data
module gf_delay_stage
  import gf_pkg::*;
#(
  parameter int WIDTH = GF_M
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             squash,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_out,
  output logic [WIDTH-1:0] d_out
);

  // Bubbles carry 0, the additive identity, so downstream XOR
  // accumulators are unaffected by invalid slots.
  function automatic logic [WIDTH-1:0] squash_word(input logic       sq,
                                                   input logic       vld,
                                                   input logic [WIDTH-1:0] w);
    return (sq && !vld) ? '0 : w;
  endfunction

  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;

  // ---- stage register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (clr) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (en) begin
      vld_p0  <= v_in;
      data_p0 <= squash_word(squash, v_in, d_in);
    end
  end

  assign v_out = vld_p0;
  assign d_out = data_p0;

endmodule

// File: rtl/gf_delay_line.sv
// gf_delay_line: stallable, flushable delay line used to skew operands and
// partial products between systolic cells of the GF(2^m) multiplier.
// Ports:
//   clk       in  rising-edge clock
//   rst       in  asynchronous active-low reset
//   en        in  1 = every slot shifts one position, 0 = every slot holds
//   clr       in  synchronous flush of all slots (beats en)
//   in_valid  in  qualifies d
//   d         in  input word
//   out_valid out valid of the last slot
//   q         out data of the last slot (registered, no path from d)
//   fill      out number of slots currently holding a valid word
module gf_delay_line
  import gf_pkg::*;
#(
  parameter int WIDTH  = GF_M,
  parameter int DEPTH  = 4,
  parameter bit SQUASH = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        clr,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            d,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            q,
  output logic [clog2(DEPTH+1)-1:0]   fill
);

  localparam int FILL_W = clog2(DEPTH + 1);

  // Element 0 is the line input; element i is the output of slot i-1.
  logic             v_bus [DEPTH+1];
  logic [WIDTH-1:0] d_bus [DEPTH+1];

  assign v_bus[0] = in_valid;
  assign d_bus[0] = d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    gf_delay_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .clr    (clr),
      .squash (SQUASH),
      .v_in   (v_bus[i]),
      .d_in   (d_bus[i]),
      .v_out  (v_bus[i+1]),
      .d_out  (d_bus[i+1])
    );
  end

  assign out_valid = v_bus[DEPTH];
  assign q         = d_bus[DEPTH];

  // ---- occupancy counter, updated on the same edge as the slots ----
  // One word enters and one leaves per shift, so the count can only move
  // by the difference of the entering and exiting valids and never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill <= '0;
    end else if (clr) begin
      fill <= '0;
    end else if (en) begin
      fill <= fill + FILL_W'(in_valid) - FILL_W'(v_bus[DEPTH]);
    end
  end

  logic [FILL_W-1:0] v_count;
  always_comb begin
    v_count = '0;
    for (int i = 1; i <= DEPTH; i++) begin
      v_count = v_count + FILL_W'(v_bus[i]);
    end
  end

  fill_matches_valids: assert property (@(posedge clk) disable iff (!rst)
                                        fill == v_count);

endmodule
